// File: rtl/updown_counter_mod.sv
// Parametrised up/down event counter: prescaler, clamped load, tc pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module updown_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrapped
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_out;
    logic [PW-1:0]    r_ps;
    logic             r_tc;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;
    logic             w_tick;
    logic             w_bound;

    assign w_tick  = (r_ps == PS_LAST);
    assign w_bound = up_down ? (r_out == MAX) : (r_out == '0);
    assign w_load  = (load_val > MAX) ? MAX : load_val;

    // At a bound the value either wraps or, when saturating, holds.
    always_comb begin
        w_step = r_out;
        if (!w_bound) begin
            w_step = up_down ? (r_out + 1'b1) : (r_out - 1'b1);
        end
`ifndef UPDOWN_COUNTER_SATURATE_EN
        else begin
            w_step = up_down ? '0 : MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out <= '0;
            r_ps  <= '0;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_out <= w_load;
            r_ps  <= '0;
            r_tc  <= 1'b0;
        end else if (enable) begin
            if (w_tick) begin
                r_ps  <= '0;
                r_out <= w_step;
                r_tc  <= w_bound;
            end else begin
                r_ps  <= r_ps + 1'b1;
                r_tc  <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

`ifdef UPDOWN_COUNTER_SATURATE_EN
    assign wrapped = 1'b0;
`else
    logic r_wrapped;

    always_ff @(posedge clk) begin
        if (!reset || load) begin
            r_wrapped <= 1'b0;
        end else if (enable && w_tick && w_bound) begin
            r_wrapped <= 1'b1;
        end
    end

    assign wrapped = r_wrapped;
`endif

    assign out = r_out;
    assign tc  = r_tc;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: four parameterisations share stimulus.
// Expectations track the wrap or saturate build via UPDOWN_COUNTER_SATURATE_EN.
module tb_updown_counter_mod;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] out0, out1, out2, out3;
    logic       tc0, tc1, tc2, tc3;
    logic       wr0, wr1, wr2, wr3;

    int n_checks = 0;
    int n_fail   = 0;

    // Defaults: legacy up_counter behaviour.
    updown_counter_mod u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .out(out0), .tc(tc0), .wrapped(wr0)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .out(out1), .tc(tc1), .wrapped(wr1)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .out(out2), .tc(tc2), .wrapped(wr2)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(1), .PRESCALE(1)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .out(out3), .tc(tc3), .wrapped(wr3)
    );

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        enable   = 1'b1;
        up_down  = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        edge1();
        edge1();
        n_checks++;
        if ({out0, out1, out2, out3} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected 0000",
                     {out0, out1, out2, out3});
        end
        n_checks++;
        if ({tc0, tc1, tc2, tc3, wr0, wr1, wr2, wr3} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {tc0, tc1, tc2, tc3, wr0, wr1, wr2, wr3});
        end
    endtask

    task automatic test_legacy();
        logic [3:0] eo;
        logic       et, ew;
        reset   = 1'b1;
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            edge1();
            if (SAT) begin
                eo = (k > 15) ? 4'd15 : 4'(k);
                et = (k >= 16);
                ew = 1'b0;
            end else begin
                eo = 4'(k % 16);
                et = (k == 16);
                ew = (k >= 16);
            end
            n_checks++;
            if ({out0, tc0, wr0} !== {eo, et, ew}) begin
                n_fail++;
                $display("FAIL legacy[%0d]: got out=%0d tc=%b wr=%b expected out=%0d tc=%b wr=%b",
                         k, out0, tc0, wr0, eo, et, ew);
            end
        end
    endtask

    task automatic test_down_prescale();
        int eo_w [7] = '{1, 1, 0, 0, 0, 9, 9};
        int eo_s [7] = '{1, 1, 0, 0, 0, 0, 0};
        int et_a [7] = '{0, 0, 0, 0, 0, 1, 0};
        logic [3:0] eo;
        logic       et, ew;
        load     = 1'b1;
        load_val = 4'd1;
        enable   = 1'b0;
        edge1();
        n_checks++;
        if ({out1, tc1, wr1} !== {4'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL dnps_load: got out=%0d tc=%b wr=%b expected out=1 tc=0 wr=0",
                     out1, tc1, wr1);
        end
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b0;
        for (int k = 0; k < 7; k++) begin
            edge1();
            eo = SAT ? 4'(eo_s[k]) : 4'(eo_w[k]);
            et = et_a[k][0];
            ew = !SAT && (k >= 5);
            n_checks++;
            if ({out1, tc1, wr1} !== {eo, et, ew}) begin
                n_fail++;
                $display("FAIL dnps[%0d]: got out=%0d tc=%b wr=%b expected out=%0d tc=%b wr=%b",
                         k, out1, tc1, wr1, eo, et, ew);
            end
        end
    endtask

    task automatic test_load_clamp();
        load     = 1'b1;
        enable   = 1'b1;
        up_down  = 1'b1;
        load_val = 4'd12;
        edge1();
        n_checks++;
        if ({out1, tc1, wr1, out2, tc2, wr2} !== {4'd9, 2'b00, 4'd9, 2'b00}) begin
            n_fail++;
            $display("FAIL clamp: got d1=%0d/%b/%b d2=%0d/%b/%b expected 9/0/0 9/0/0",
                     out1, tc1, wr1, out2, tc2, wr2);
        end
        load = 1'b0;
        edge1();
        n_checks++;
        if ({out2, tc2, wr2} !== {(SAT ? 4'd9 : 4'd0), 1'b1, !SAT}) begin
            n_fail++;
            $display("FAIL clamp_wrap: got out=%0d tc=%b wr=%b expected out=%0d tc=1 wr=%b",
                     out2, tc2, wr2, SAT ? 9 : 0, !SAT);
        end
        for (int k = 0; k < 3; k++) begin
            logic [3:0] eo;
            logic       et;
            if (k > 0) edge1();
            eo = (k < 2 || SAT) ? 4'd9 : 4'd0;
            et = (k == 2);
            n_checks++;
            if ({out1, tc1} !== {eo, et}) begin
                n_fail++;
                $display("FAIL clamp_ps[%0d]: got out=%0d tc=%b expected out=%0d tc=%b",
                         k, out1, tc1, eo, et);
            end
        end
    endtask

    task automatic test_reset_mid();
        load     = 1'b1;
        load_val = 4'd7;
        enable   = 1'b0;
        edge1();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        edge1();
        n_checks++;
        if (out1 !== 4'd7) begin
            n_fail++;
            $display("FAIL rmid_pre: got out=%0d expected out=7", out1);
        end
        reset    = 1'b0;
        load     = 1'b1;
        load_val = 4'd5;
        edge1();
        n_checks++;
        if ({out1, tc1, wr1, out0, out2} !== {4'd0, 2'b00, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL rmid_rst: got d1=%0d/%b/%b d0=%0d d2=%0d expected 0/0/0 0 0",
                     out1, tc1, wr1, out0, out2);
        end
        reset = 1'b1;
        load  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] eo;
            edge1();
            eo = (k == 2) ? 4'd1 : 4'd0;
            n_checks++;
            if ({out1, tc1} !== {eo, 1'b0}) begin
                n_fail++;
                $display("FAIL rmid_run[%0d]: got out=%0d tc=%b expected out=%0d tc=0",
                         k, out1, tc1, eo);
            end
        end
    endtask

    task automatic test_enable_gap();
        load     = 1'b1;
        load_val = 4'd5;
        enable   = 1'b0;
        edge1();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        edge1();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge1();
            n_checks++;
            if ({out1, tc1, wr1} !== {4'd5, 2'b00}) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: got out=%0d tc=%b wr=%b expected out=5 tc=0 wr=0",
                         k, out1, tc1, wr1);
            end
        end
        enable = 1'b1;
        edge1();
        n_checks++;
        if (out1 !== 4'd5) begin
            n_fail++;
            $display("FAIL gap_resume0: got out=%0d expected out=5", out1);
        end
        edge1();
        n_checks++;
        if ({out1, tc1} !== {4'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL gap_resume1: got out=%0d tc=%b expected out=6 tc=0",
                     out1, tc1);
        end
    endtask

    task automatic test_bound();
        int eo_w [4] = '{15, 0, 1, 0};
        int eo_s [4] = '{15, 15, 15, 14};
        int et_w [4] = '{0, 1, 0, 0};
        int et_s [4] = '{0, 1, 1, 0};
        logic [3:0] eo;
        logic       et, ew;
        load     = 1'b1;
        load_val = 4'd14;
        enable   = 1'b0;
        edge1();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) up_down = 1'b0;
            edge1();
            eo = SAT ? 4'(eo_s[k]) : 4'(eo_w[k]);
            et = SAT ? et_s[k][0] : et_w[k][0];
            ew = !SAT && (k >= 1);
            n_checks++;
            if ({out0, tc0, wr0} !== {eo, et, ew}) begin
                n_fail++;
                $display("FAIL bound[%0d]: got out=%0d tc=%b wr=%b expected out=%0d tc=%b wr=%b",
                         k, out0, tc0, wr0, eo, et, ew);
            end
        end
    endtask

    task automatic test_back_to_back();
        load     = 1'b1;
        load_val = 4'd1;
        enable   = 1'b0;
        edge1();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        edge1();
        n_checks++;
        if ({out3, tc3} !== {(SAT ? 4'd1 : 4'd0), 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_up: got out=%0d tc=%b expected out=%0d tc=1",
                     out3, tc3, SAT ? 1 : 0);
        end
        up_down = 1'b0;
        edge1();
        n_checks++;
        if ({out3, tc3} !== {(SAT ? 4'd0 : 4'd1), !SAT}) begin
            n_fail++;
            $display("FAIL b2b_dn: got out=%0d tc=%b expected out=%0d tc=%b",
                     out3, tc3, SAT ? 0 : 1, !SAT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_legacy();
        test_down_prescale();
        test_load_clamp();
        test_reset_mid();
        test_enable_gap();
        test_bound();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
